// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a PS/2 host transmitter and its client.
// The client (master) offers a byte; the transmitter (slave) reports status.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_ok,
        input  err_timeout
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_ok,
        output err_timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clk/dat enables.
// Define PS2_TX_FILTER_EN to add a 4-sample stability filter after the synchroniser.
module ps2_host_tx #(
    parameter int CLK_HZ     = 25_000_000,
    parameter int INHIBIT_US = 100,
    parameter int START_US   = 15000,
    parameter int PACKET_US  = 2000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk_i,
    input  logic         ps2_dat_i,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe,
    ps2_host_tx_if.slave bus
);

    localparam int CYC_US    = CLK_HZ / 1_000_000;
    localparam int INH_CYC   = CYC_US * INHIBIT_US;
    localparam int START_CYC = CYC_US * START_US;
    localparam int PKT_CYC   = CYC_US * PACKET_US;

    localparam int INH_W = $clog2(INH_CYC + 1);
    localparam int ST_W  = $clog2(START_CYC + 1);
    localparam int PK_W  = $clog2(PKT_CYC + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
    localparam logic [INH_W-1:0] INH_END  = INH_W'(INH_CYC);
    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(START_CYC - 1);
    localparam logic [PK_W-1:0]  PK_LAST  = PK_W'(PKT_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_dat_s1;
    logic             r_dat_s2;
    logic             r_clk_d;
    logic             w_clk;
    logic             w_dat;
    logic             w_fall;

    logic [2:0]       r_state;
    logic [9:0]       r_shift;
    logic [3:0]       r_bitcnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [ST_W-1:0]  r_start_cnt;
    logic [PK_W-1:0]  r_pkt_cnt;
    logic             r_clk_oe;
    logic             r_dat_oe;
    logic             r_done;
    logic             r_ack;
    logic             r_err;

    logic             w_ready;
    logic             w_accept;
    logic             w_in_pkt;
    logic             w_timeout;

    // Pins idle high, so the synchroniser resets to 1 to avoid a fake fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat_i;
            r_dat_s2 <= r_dat_s1;
        end
    end

`ifdef PS2_TX_FILTER_EN
    logic [2:0] r_clk_h;
    logic [2:0] r_dat_h;
    logic       r_clk_f;
    logic       r_dat_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_h <= '1;
            r_dat_h <= '1;
            r_clk_f <= 1'b1;
            r_dat_f <= 1'b1;
        end else begin
            r_clk_h <= {r_clk_h[1:0], r_clk_s2};
            r_dat_h <= {r_dat_h[1:0], r_dat_s2};
            if (&{r_clk_h, r_clk_s2}) begin
                r_clk_f <= 1'b1;
            end else if (~|{r_clk_h, r_clk_s2}) begin
                r_clk_f <= 1'b0;
            end
            if (&{r_dat_h, r_dat_s2}) begin
                r_dat_f <= 1'b1;
            end else if (~|{r_dat_h, r_dat_s2}) begin
                r_dat_f <= 1'b0;
            end
        end
    end

    assign w_clk = r_clk_f;
    assign w_dat = r_dat_f;
`else
    assign w_clk = r_clk_s2;
    assign w_dat = r_dat_s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_d <= 1'b1;
        end else begin
            r_clk_d <= w_clk;
        end
    end

    // Our own inhibit pulls the clock low; that edge is not a device clock.
    assign w_fall = r_clk_d & ~w_clk & ~r_clk_oe;

    assign w_ready  = (r_state == S_IDLE) & ~r_done;
    assign w_accept = bus.tx_valid & w_ready;
    assign w_in_pkt = (r_state == S_DATA) | (r_state == S_ACK)
                    | (r_state == S_WAIT);
    assign w_timeout = ((r_state == S_REQ) & (r_start_cnt == ST_LAST))
                     | (w_in_pkt & (r_pkt_cnt == PK_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_inh_cnt   <= '0;
            r_start_cnt <= '0;
            r_pkt_cnt   <= '0;
            r_clk_oe    <= 1'b0;
            r_dat_oe    <= 1'b0;
            r_done      <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_timeout) begin
                r_clk_oe <= 1'b0;
                r_dat_oe <= 1'b0;
                r_err    <= 1'b1;
                r_ack    <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_shift   <= {1'b1, ~^bus.tx_data, bus.tx_data};
                            r_ack     <= 1'b0;
                            r_err     <= 1'b0;
                            r_clk_oe  <= 1'b1;
                            r_inh_cnt <= '0;
                            r_state   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        // Start bit goes low one cycle before clk is released.
                        if (r_inh_cnt == INH_END) begin
                            r_clk_oe    <= 1'b0;
                            r_start_cnt <= '0;
                            r_state     <= S_REQ;
                        end else begin
                            r_inh_cnt <= r_inh_cnt + 1'b1;
                            if (r_inh_cnt == INH_LAST) begin
                                r_dat_oe <= 1'b1;
                            end
                        end
                    end
                    S_REQ: begin
                        r_start_cnt <= r_start_cnt + 1'b1;
                        if (w_fall) begin
                            r_bitcnt  <= '0;
                            r_pkt_cnt <= '0;
                            r_state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_pkt_cnt <= r_pkt_cnt + 1'b1;
                        if (w_fall) begin
                            r_dat_oe <= ~r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 4'd9) begin
                                r_state <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        r_pkt_cnt <= r_pkt_cnt + 1'b1;
                        r_dat_oe  <= 1'b0;
                        if (w_fall) begin
                            r_ack   <= ~w_dat;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        r_pkt_cnt <= r_pkt_cnt + 1'b1;
                        if (w_clk & w_dat) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2_clk_oe      = r_clk_oe;
    assign ps2_dat_oe      = r_dat_oe;
    assign bus.tx_ready    = w_ready;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.ack_ok      = r_ack;
    assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Expected frames are hand-computed {stop, parity, data, start} words.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    // Half period of 16 cycles keeps a whole frame inside the 500-cycle packet window.
    localparam int HALF = 16;

    logic clk;
    logic rst;
    logic ps2_clk_oe;
    logic ps2_dat_oe;
    logic dev_clk_pull;
    logic dev_dat_pull;
    logic ps2_clk_pin;
    logic ps2_dat_pin;
    logic dev_abort;

    int n_checks;
    int n_errors;
    int cyc_n;
    int dev_falls;
    int n_accept;
    int viol_done_ready;
    int viol_busy_ready;
    int t_clk_r;
    int t_dat_r;
    bit arm;
    logic p_clk;
    logic p_dat;

    ps2_host_tx_if u_if ();

    assign ps2_clk_pin = ~(ps2_clk_oe | dev_clk_pull);
    assign ps2_dat_pin = ~(ps2_dat_oe | dev_dat_pull);

    ps2_host_tx #(
        .CLK_HZ    (1_000_000),
        .INHIBIT_US(100),
        .START_US  (1000),
        .PACKET_US (500)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk_i (ps2_clk_pin),
        .ps2_dat_i (ps2_dat_pin),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .bus       (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        #1;
        if (ps2_clk_oe && !p_clk) begin
            t_clk_r = cyc_n;
            arm = 1'b1;
        end
        if (ps2_dat_oe && !p_dat && arm) begin
            t_dat_r = cyc_n;
            arm = 1'b0;
        end
        p_clk = ps2_clk_oe;
        p_dat = ps2_dat_oe;
    end

    always @(negedge clk) begin
        if (u_if.tx_valid && u_if.tx_ready) n_accept++;
        if (u_if.done && u_if.tx_ready) viol_done_ready++;
        if (u_if.busy && u_if.tx_ready) viol_busy_ready++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        u_if.tx_data  = b;
        u_if.tx_valid = 1'b1;
        cyc(1);
        u_if.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit seen, output int at);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            #1;
            if (u_if.done) begin
                seen = 1'b1;
                at   = cyc_n;
                return;
            end
        end
    endtask

    task automatic dev_xfer(input bit do_ack, output logic [10:0] got,
                            output bit seen);
        got  = '0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (ps2_clk_pin && !ps2_dat_pin) begin
                seen = 1'b1;
                break;
            end
            cyc(1);
        end
        if (!seen) return;
        cyc(20);
        for (int i = 0; i < 11; i++) begin
            if (dev_abort) begin
                dev_clk_pull = 1'b0;
                dev_dat_pull = 1'b0;
                return;
            end
            dev_clk_pull = 1'b1;
            dev_falls++;
            cyc(HALF);
            got[i] = ps2_dat_pin;
            dev_clk_pull = 1'b0;
            cyc(HALF);
        end
        if (dev_abort) return;
        cyc(HALF / 2);
        dev_dat_pull = do_ack;
        cyc(HALF / 2);
        dev_clk_pull = 1'b1;
        dev_falls++;
        cyc(HALF);
        dev_clk_pull = 1'b0;
        cyc(HALF / 2);
        dev_dat_pull = 1'b0;
    endtask

    logic [10:0] got;
    bit          seen;
    bit          dseen;
    int          dat;
    int          acc0;
    bit          reached;

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        cyc_n           = 0;
        dev_falls       = 0;
        n_accept        = 0;
        viol_done_ready = 0;
        viol_busy_ready = 0;
        t_clk_r         = 0;
        t_dat_r         = 0;
        arm             = 1'b0;
        p_clk           = 1'b0;
        p_dat           = 1'b0;
        dev_clk_pull    = 1'b0;
        dev_dat_pull    = 1'b0;
        dev_abort       = 1'b0;
        u_if.tx_data    = 8'h00;
        u_if.tx_valid   = 1'b0;
        rst             = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(3);

        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_ready", u_if.tx_ready, 1);
        chk("rst_busy", u_if.busy, 0);
        chk("rst_done", u_if.done, 0);
        chk("rst_ack_err", {u_if.ack_ok, u_if.err_timeout}, 0);

        // 1: 0xF4, five ones -> parity 0
        send(8'hF4);
        chk("t1_busy", u_if.busy, 1);
        fork
            dev_xfer(1'b1, got, seen);
            wait_done(3000, dseen, dat);
        join
        chk("t1_req", seen, 1);
        chk("t1_frame", got, 11'h5E8);
        chk("t1_done", dseen, 1);
        chk("t1_ack", u_if.ack_ok, 1);
        chk("t1_err", u_if.err_timeout, 0);
        cyc(20);

        // 2: 0xFF, eight ones -> parity 1; inhibit length
        send(8'hFF);
        fork
            dev_xfer(1'b1, got, seen);
            wait_done(3000, dseen, dat);
        join
        chk("t2_frame", got, 11'h7FE);
        chk("t2_done", dseen, 1);
        chk("t2_ack", u_if.ack_ok, 1);
        chk("t2_inhibit", t_dat_r - t_clk_r, 100);
        cyc(20);

        // 3: silent device -> start timeout
        send(8'hF4);
        wait_done(3000, dseen, dat);
        chk("t3_done", dseen, 1);
        chk("t3_lat", (dat - t_dat_r >= 995) && (dat - t_dat_r <= 1010), 1);
        chk("t3_err", u_if.err_timeout, 1);
        chk("t3_ack", u_if.ack_ok, 0);
        chk("t3_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        cyc(10);
        chk("t3_err_hold", u_if.err_timeout, 1);

        // 4: device nacks
        send(8'hF4);
        chk("t4_err_clr", u_if.err_timeout, 0);
        fork
            dev_xfer(1'b0, got, seen);
            wait_done(3000, dseen, dat);
        join
        chk("t4_done", dseen, 1);
        chk("t4_ack", u_if.ack_ok, 0);
        chk("t4_err", u_if.err_timeout, 0);
        cyc(20);

        // 5: reset during data bit 4 (0xE0 bit 4 = 0 -> dat_oe held)
        dev_falls = 0;
        send(8'hE0);
        fork
            dev_xfer(1'b1, got, seen);
            begin
                reached = 1'b0;
                for (int i = 0; i < 2000; i++) begin
                    if (dev_falls == 6) begin
                        reached = 1'b1;
                        break;
                    end
                    cyc(1);
                end
                chk("t5_reach", reached, 1);
                cyc(10);
                chk("t5_pre_dat", ps2_dat_oe, 1);
                #2;
                rst = 1'b1;
                #1;
                chk("t5_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
                chk("t5_ready", u_if.tx_ready, 1);
                chk("t5_busy", u_if.busy, 0);
                dev_abort = 1'b1;
                cyc(3);
                rst = 1'b0;
            end
        join
        dev_abort    = 1'b0;
        dev_clk_pull = 1'b0;
        dev_dat_pull = 1'b0;
        cyc(50);
        send(8'hED);
        fork
            dev_xfer(1'b1, got, seen);
            wait_done(3000, dseen, dat);
        join
        chk("t5_frame", got, 11'h7DA);
        chk("t5_done", dseen, 1);
        chk("t5_ack", u_if.ack_ok, 1);
        cyc(20);

        // 6: tx_valid held for the whole transfer
        acc0 = n_accept;
        @(posedge clk);
        #1;
        u_if.tx_data  = 8'hF4;
        u_if.tx_valid = 1'b1;
        fork
            dev_xfer(1'b1, got, seen);
            wait_done(3000, dseen, dat);
        join
        u_if.tx_valid = 1'b0;
        cyc(5);
        chk("t6_done", dseen, 1);
        chk("t6_ack", u_if.ack_ok, 1);
        chk("t6_accepts", n_accept - acc0, 1);
        chk("t6_busy", u_if.busy, 0);

        chk("done_ready_excl", viol_done_ready, 0);
        chk("busy_ready_excl", viol_busy_ready, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
